booth_mul_seq: RTL and testbench
================================

BOOTH_MUL_SEQ -- requirements
Module: booth_mul_seq

Interface
REQ-001 SHALL have parameter DWIDTH, default 24, meaning operand width (legal range 4..64).
REQ-002 SHALL derive localparams MW = 2*((DWIDTH+2)/2) (internal multiplier width) and ITER = MW/2 (maximum digit count).
REQ-003 SHALL have port clk  input  1  the single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst_n  input  1  reset; asynchronous, active-low.
REQ-005 SHALL have port in_valid  input  1  request valid.
REQ-006 SHALL have port in_ready  output  1  block can accept.
REQ-007 SHALL have port in_a  input  DWIDTH  multiplicand.
REQ-008 SHALL have port in_b  input  DWIDTH  multiplier.
REQ-009 SHALL have port in_signed  input  1  1 = two's-complement operands, 0 = unsigned.
REQ-010 SHALL have port out_valid  output  1  product valid.
REQ-011 SHALL have port out_ready  input  1  consumer accepts.
REQ-012 SHALL have port out_p  output  2*DWIDTH  product.
REQ-013 SHALL have port busy  output  1  high whenever state is not IDLE.

Function
REQ-014 SHALL implement FSM states IDLE, RUN, DONE.
REQ-015 SHALL accept when in_valid & in_ready; in_ready = (state==IDLE) | (state==DONE & out_ready).
REQ-016 On accept, SHALL load in_a extended to 2*DWIDTH+2 bits into the multiplicand register and in_b extended to MW bits into the multiplier register (sign-extend if in_signed, else zero-extend), clear the accumulator, set prev bit = 0, count = 0, and enter RUN.
REQ-017 Each RUN edge SHALL recode {mul[1],mul[0],prev} as a radix-4 Booth digit in {0,+1,+2,-1,-2}, add the selected multiple of the multiplicand to the accumulator, shift the multiplicand left by 2 and the multiplier right by 2 (arithmetic), set prev = old mul[1], and increment count.
REQ-018 SHALL realise negative digits as the inverted multiple plus a carry-in of 1 into the same addition, with no extra cycle.
REQ-019 SHALL enter DONE after the edge where count reaches ITER; out_valid SHALL then be high, giving a latency of ITER cycles from the accept edge.
REQ-020 out_p SHALL equal accumulator[2*DWIDTH-1:0] and SHALL remain stable while out_valid & ~out_ready.
REQ-021 On DONE & out_ready & ~in_valid, SHALL return to IDLE; on DONE & out_ready & in_valid, SHALL accept the new operands in the same edge (back-to-back, no bubble).
REQ-022 in_valid in RUN SHALL be ignored; operands SHALL NOT be sampled except at accept.
REQ-023 SHALL produce the exact product for all operand pairs in both modes, including signed -2^(DWIDTH-1) * -2^(DWIDTH-1).

Reset
REQ-024 rst_n low SHALL immediately force state IDLE, out_valid 0, busy 0, in_ready 1, out_p 0, and all internal registers 0, including mid-RUN; no result from an aborted operation SHALL ever appear.

Configuration
REQ-025 Macro BOOTH_MUL_EARLY_TERM_EN defined: after each RUN edge, if all remaining multiplier bits and prev are equal (all 0 or all 1), SHALL enter DONE immediately; latency is 1..ITER cycles.
REQ-026 Macro undefined: latency SHALL be exactly ITER cycles for every operand.

Structure
REQ-027 Package booth_pkg SHALL hold the Booth digit encodings (0, P1, P2, N1, N2 as 3-bit constants) and the FSM state typedef/encoding.
REQ-028 One combinational sub-module, booth_pp_sel, SHALL perform digit recoding plus multiple selection and emit the negate flag; the accumulator adder SHALL remain in booth_mul_seq.

Verification (DWIDTH=8: MW=10, ITER=5)
REQ-029 Unsigned 0xFF*0xFF -> out_p=0xFE01, out_valid 5 cycles after accept (early-term off).
REQ-030 Signed 0x80*0x80 -> 0x4000; signed 0xFF*0x01 -> 0xFFFF; unsigned 0x80*0x80 -> 0x4000.
REQ-031 Hold out_ready low 10 cycles after out_valid -> out_p stable, in_ready 0; then assert out_ready with in_valid -> next operands accepted on that same edge and the next result arrives with no bubble.
REQ-032 Deassert rst_n 2 cycles into RUN -> out_valid 0, in_ready 1 immediately; after release, no stale out_valid appears.
REQ-033 With BOOTH_MUL_EARLY_TERM_EN, unsigned 3*1 and 5*0 -> out_valid after 1 cycle; 0x7F*0x7F -> 4 cycles; without the macro all three take 5 cycles; results equal the products.
REQ-034 Randomised check of 10k pairs in both modes against a reference product, with random valid/ready throttling.

Source files
------------

// File: rtl/booth_pkg.sv
// rtl/booth_pkg.sv - Radix-4 Booth digit encodings and FSM state type for booth_mul_seq.
package booth_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  // Bit 2 flags a negative digit, bits 1:0 give the magnitude.
  localparam logic [2:0] BD_ZERO = 3'b000;
  localparam logic [2:0] BD_P1   = 3'b001;
  localparam logic [2:0] BD_P2   = 3'b010;
  localparam logic [2:0] BD_N1   = 3'b101;
  localparam logic [2:0] BD_N2   = 3'b110;

endpackage

// File: rtl/booth_pp_sel.sv
// rtl/booth_pp_sel.sv - Booth digit recoding and partial-product selection.
// Negative digits come out bit-inverted; the caller adds o_neg as carry-in.
module booth_pp_sel
  import booth_pkg::*;
#(
  parameter int PW = 18
) (
  input  logic [2:0]    i_bits,
  input  logic [PW-1:0] i_mcand,
  output logic [PW-1:0] o_pp,
  output logic          o_neg
);

  logic [2:0]    w_digit;
  logic [PW-1:0] w_mult;

  always_comb begin
    w_digit = BD_ZERO;
    case (i_bits)
      3'b001, 3'b010: w_digit = BD_P1;
      3'b011:         w_digit = BD_P2;
      3'b100:         w_digit = BD_N2;
      3'b101, 3'b110: w_digit = BD_N1;
      default:        w_digit = BD_ZERO;
    endcase
  end

  always_comb begin
    w_mult = '0;
    case (w_digit[1:0])
      2'b01:   w_mult = i_mcand;
      2'b10:   w_mult = {i_mcand[PW-2:0], 1'b0};
      default: w_mult = '0;
    endcase
  end

  assign o_neg = w_digit[2];
  assign o_pp  = w_digit[2] ? ~w_mult : w_mult;

endmodule

// File: rtl/booth_mul_seq.sv
// rtl/booth_mul_seq.sv - Sequential radix-4 Booth multiplier, one digit per cycle, valid/ready handshake.
// Define BOOTH_MUL_EARLY_TERM_EN to finish as soon as the remaining digits are all zero.
module booth_mul_seq
  import booth_pkg::*;
#(
  parameter int DWIDTH = 24
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [DWIDTH-1:0]   in_a,
  input  logic [DWIDTH-1:0]   in_b,
  input  logic                in_signed,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [2*DWIDTH-1:0] out_p,
  output logic                busy
);

  localparam int MW   = 2 * ((DWIDTH + 2) / 2);
  localparam int ITER = MW / 2;
  localparam int PW   = 2 * DWIDTH + 2;
  localparam int CW   = $clog2(ITER + 1);

  state_t        r_state;
  state_t        w_state_nxt;
  logic [PW-1:0] r_mcand;
  logic [PW-1:0] r_acc;
  logic [MW-1:0] r_mul;
  logic          r_prev;
  logic [CW-1:0] r_cnt;

  logic [PW-1:0] w_a_ext;
  logic [MW-1:0] w_b_ext;
  logic [PW-1:0] w_pp;
  logic          w_neg;
  logic [PW-1:0] w_acc_sum;
  logic [MW-1:0] w_mul_sh;
  logic          w_accept;
  logic          w_run_done;

  assign in_ready  = (r_state == ST_IDLE) | ((r_state == ST_DONE) & out_ready);
  assign w_accept  = in_valid & in_ready;
  assign out_valid = (r_state == ST_DONE);
  assign busy      = (r_state != ST_IDLE);
  assign out_p     = r_acc[2*DWIDTH-1:0];

  assign w_a_ext  = {{(PW-DWIDTH){in_signed & in_a[DWIDTH-1]}}, in_a};
  assign w_b_ext  = {{(MW-DWIDTH){in_signed & in_b[DWIDTH-1]}}, in_b};
  assign w_mul_sh = {{2{r_mul[MW-1]}}, r_mul[MW-1:2]};

  booth_pp_sel #(
    .PW (PW)
  ) u_pp_sel (
    .i_bits  ({r_mul[1:0], r_prev}),
    .i_mcand (r_mcand),
    .o_pp    (w_pp),
    .o_neg   (w_neg)
  );

  // Carry-in completes the two's-complement negation of inverted multiples.
  assign w_acc_sum = r_acc + w_pp + {{(PW-1){1'b0}}, w_neg};

`ifdef BOOTH_MUL_EARLY_TERM_EN
  logic [MW:0] w_rem;
  assign w_rem      = {w_mul_sh, r_mul[1]};
  assign w_run_done = (r_cnt == CW'(ITER - 1)) | (&w_rem) | ~(|w_rem);
`else
  assign w_run_done = (r_cnt == CW'(ITER - 1));
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: if (in_valid) w_state_nxt = ST_RUN;
      ST_RUN:  if (w_run_done) w_state_nxt = ST_DONE;
      ST_DONE: if (out_ready) w_state_nxt = in_valid ? ST_RUN : ST_IDLE;
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_mcand <= '0;
      r_acc   <= '0;
      r_mul   <= '0;
      r_prev  <= 1'b0;
      r_cnt   <= '0;
    end else if (w_accept) begin
      r_mcand <= w_a_ext;
      r_acc   <= '0;
      r_mul   <= w_b_ext;
      r_prev  <= 1'b0;
      r_cnt   <= '0;
    end else if (r_state == ST_RUN) begin
      r_acc   <= w_acc_sum;
      r_mcand <= {r_mcand[PW-3:0], 2'b00};
      r_mul   <= w_mul_sh;
      r_prev  <= r_mul[1];
      r_cnt   <= r_cnt + CW'(1);
    end
  end

endmodule

// File: tb/tb_booth_mul_seq.sv
// tb/tb_booth_mul_seq.sv - Directed self-checking bench for booth_mul_seq at DWIDTH=8.
module tb_booth_mul_seq;

  localparam int DW = 8;
`ifdef BOOTH_MUL_EARLY_TERM_EN
  localparam int ET = 1;
`else
  localparam int ET = 0;
`endif

  logic            clk = 1'b0;
  logic            rst_n;
  logic            in_valid;
  logic            in_ready;
  logic [DW-1:0]   in_a;
  logic [DW-1:0]   in_b;
  logic            in_signed;
  logic            out_valid;
  logic            out_ready;
  logic [2*DW-1:0] out_p;
  logic            busy;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  booth_mul_seq #(
    .DWIDTH (DW)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_a      (in_a),
    .in_b      (in_b),
    .in_signed (in_signed),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_p     (out_p),
    .busy      (busy)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Caller guarantees the DUT is idle; exp_lat of 0 skips the latency check.
  task automatic run_op(input string tag, input logic [7:0] a, input logic [7:0] b,
                        input logic s, input logic [15:0] exp_p, input int exp_lat,
                        input int hold);
    int lat;
    in_a      = a;
    in_b      = b;
    in_signed = s;
    in_valid  = 1'b1;
    out_ready = 1'b0;
    step();
    in_valid = 1'b0;
    in_a     = 8'($urandom);
    in_b     = 8'($urandom);
    lat      = 0;
    while (!out_valid && lat < 40) begin
      step();
      lat++;
    end
    check({tag, "_p"}, 64'(out_p), 64'(exp_p));
    if (exp_lat > 0) check({tag, "_lat"}, 64'(lat), 64'(exp_lat));
    repeat (hold) step();
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
  endtask

  function automatic logic [15:0] ref_mul(input logic [7:0] a, input logic [7:0] b, input logic s);
    logic [15:0] ax;
    logic [15:0] bx;
    ax = s ? {{8{a[7]}}, a} : {8'h00, a};
    bx = s ? {{8{b[7]}}, b} : {8'h00, b};
    return ax * bx;
  endfunction

  initial begin
    int lat;
    int stale;
    logic [7:0] ra;
    logic [7:0] rb;
    logic       rs;

    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_a      = '0;
    in_b      = '0;
    in_signed = 1'b0;
    out_ready = 1'b0;
    repeat (3) step();
    check("rst_out_valid", 64'(out_valid), 64'(0));
    check("rst_in_ready",  64'(in_ready),  64'(1));
    check("rst_busy",      64'(busy),      64'(0));
    check("rst_out_p",     64'(out_p),     64'(0));
    rst_n = 1'b1;
    step();

    run_op("u_ff_ff",   8'hFF, 8'hFF, 1'b0, 16'hFE01, 5,            0);
    run_op("s_80_80",   8'h80, 8'h80, 1'b1, 16'h4000, ET ? 0 : 5,   0);
    run_op("s_ff_01",   8'hFF, 8'h01, 1'b1, 16'hFFFF, ET ? 0 : 5,   1);
    run_op("u_80_80",   8'h80, 8'h80, 1'b0, 16'h4000, ET ? 0 : 5,   0);
    run_op("s_7f_80",   8'h7F, 8'h80, 1'b1, 16'hC080, ET ? 0 : 5,   2);
    run_op("s_ff_ff",   8'hFF, 8'hFF, 1'b1, 16'h0001, ET ? 0 : 5,   0);
    run_op("u_03_01",   8'h03, 8'h01, 1'b0, 16'h0003, ET ? 1 : 5,   0);
    run_op("u_05_00",   8'h05, 8'h00, 1'b0, 16'h0000, ET ? 1 : 5,   0);
    run_op("u_7f_7f",   8'h7F, 8'h7F, 1'b0, 16'h3F01, ET ? 4 : 5,   0);

    // Back-pressure hold, then back-to-back accept on the releasing edge.
    in_a      = 8'd12;
    in_b      = 8'd13;
    in_signed = 1'b0;
    in_valid  = 1'b1;
    out_ready = 1'b0;
    step();
    in_valid = 1'b0;
    lat = 0;
    while (!out_valid && lat < 40) begin
      step();
      lat++;
    end
    check("bp_first_p", 64'(out_p), 64'h009C);
    for (int i = 0; i < 10; i++) begin
      step();
      check("bp_hold_p",     64'(out_p),     64'h009C);
      check("bp_hold_ready", 64'(in_ready),  64'(0));
      check("bp_hold_valid", 64'(out_valid), 64'(1));
    end
    in_a      = 8'hFD;
    in_b      = 8'h07;
    in_signed = 1'b1;
    in_valid  = 1'b1;
    out_ready = 1'b1;
    #1;
    check("b2b_in_ready", 64'(in_ready), 64'(1));
    step();
    in_valid  = 1'b0;
    out_ready = 1'b0;
    in_a      = 8'h55;
    in_b      = 8'hAA;
    check("b2b_valid_dropped", 64'(out_valid), 64'(0));
    check("b2b_busy",          64'(busy),      64'(1));
    lat = 0;
    while (!out_valid && lat < 40) begin
      step();
      lat++;
    end
    check("b2b_p",   64'(out_p), 64'hFFEB);
    check("b2b_lat", 64'(lat),   64'(ET ? 2 : 5));
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;

    // Asynchronous reset two cycles into RUN.
    in_a      = 8'hAB;
    in_b      = 8'hCD;
    in_signed = 1'b0;
    in_valid  = 1'b1;
    step();
    in_valid = 1'b0;
    step();
    step();
    check("mid_busy_before", 64'(busy), 64'(1));
    rst_n = 1'b0;
    #1;
    check("mid_rst_out_valid", 64'(out_valid), 64'(0));
    check("mid_rst_in_ready",  64'(in_ready),  64'(1));
    check("mid_rst_busy",      64'(busy),      64'(0));
    check("mid_rst_out_p",     64'(out_p),     64'(0));
    step();
    step();
    rst_n     = 1'b1;
    out_ready = 1'b1;
    stale     = 0;
    for (int i = 0; i < 12; i++) begin
      step();
      if (out_valid) stale++;
    end
    out_ready = 1'b0;
    check("mid_rst_no_stale", 64'(stale), 64'(0));

    for (int i = 0; i < 300; i++) begin
      ra = 8'($urandom);
      rb = 8'($urandom);
      rs = 1'($urandom);
      repeat ($urandom_range(0, 2)) step();
      run_op("rnd", ra, rb, rs, ref_mul(ra, rb, rs), ET ? 0 : 5, $urandom_range(0, 3));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
